// File: rtl/sobel_pkg.sv
// Shared types for the 3-line window front end: controller state and
// window-mux rotation codes.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_READ = 2'd2,
        ST_LAST = 2'd3
    } lb_state_e;

    localparam logic [1:0] RD_ROT_A = 2'b00;
    localparam logic [1:0] RD_ROT_B = 2'b01;
    localparam logic [1:0] RD_ROT_C = 2'b10;

    // Rotation for a read pass is fixed by which RAM holds the newest line.
    function automatic logic [1:0] rot_for_line(input logic [1:0] line_mod3);
        logic [1:0] rot;
        case (line_mod3)
            2'd0:    rot = RD_ROT_C;
            2'd1:    rot = RD_ROT_A;
            default: rot = RD_ROT_B;
        endcase
        return rot;
    endfunction

    function automatic logic [2:0] ram_onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/mod3_rot_cnt.sv
// Wrapping 0..2 counter selecting which line RAM receives the current line.
module mod3_rot_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [1:0] idx
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= 2'd0;
        end else if (inc) begin
            idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: writes incoming lines round-robin into three line
// RAMs and sweeps a read pass per line to feed a 3-line window mux.
module line_buffer_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ADDR_WD = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [2:0]         wr_en,
    output logic [ADDR_WD-1:0] wr_addr,
    output logic [ADDR_WD-1:0] rd_addr,
    output logic [1:0]         rd_ram,
    output logic               first_line,
    output logic               last_line,
    output logic               win_valid,
    output logic [ADDR_WD-1:0] win_col,
    output logic               frame_done
);

    localparam int LINE_WD = $clog2(IMG_H + 1);
    localparam logic [ADDR_WD-1:0] COL_LAST = ADDR_WD'(IMG_W - 1);
    localparam logic [LINE_WD-1:0] LINE_ZERO = '0;
    localparam logic [LINE_WD-1:0] LINE_TWO  = LINE_WD'(2);
    localparam logic [LINE_WD-1:0] LINE_ALL  = LINE_WD'(IMG_H);

    lb_state_e          state, state_nxt;
    logic [ADDR_WD-1:0] col;
    logic [LINE_WD-1:0] line;
    logic [1:0]         wr_idx;
    logic [1:0]         rd_rot;
    logic               frame_start, beat, line_done, reading, pass_done, col_step;
    logic               done_pend;

    assign frame_start = (state == ST_IDLE) && start;
    assign beat        = (state == ST_FILL) && pix_valid;
    assign line_done   = beat && (col == COL_LAST);
    assign reading     = (state == ST_READ) || (state == ST_LAST);
    assign pass_done   = reading && (col == COL_LAST);
    assign col_step    = beat || reading;

    mod3_rot_cnt u_rot (
        .clk (clk),
        .rst (rst),
        .clr (frame_start),
        .inc (line_done),
        .idx (wr_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // line counts completed lines: during FILL it is the line being written,
    // during READ it is one past the line just written.
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        wr_en     = 3'b000;
        wr_addr   = '0;
        rd_addr   = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                pix_ready = 1'b1;
                wr_addr   = col;
                if (beat) wr_en = ram_onehot(wr_idx);
                if (line_done && (line != LINE_ZERO)) state_nxt = ST_READ;
            end
            ST_READ: begin
                rd_addr = col;
                if (pass_done) state_nxt = (line == LINE_ALL) ? ST_LAST : ST_FILL;
            end
            ST_LAST: begin
                rd_addr = col;
                if (pass_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            line   <= '0;
            rd_rot <= RD_ROT_A;
        end else begin
            if (frame_start) begin
                col  <= '0;
                line <= '0;
            end else if (col_step) begin
                col <= (col == COL_LAST) ? '0 : col + 1'b1;
            end
            if (line_done) begin
                line   <= line + 1'b1;
                rd_rot <= rot_for_line(wr_idx);
            end
        end
    end

    // Window qualifiers trail rd_addr by one cycle to line up with RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid  <= 1'b0;
            win_col    <= '0;
            first_line <= 1'b0;
            last_line  <= 1'b0;
            rd_ram     <= RD_ROT_A;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= reading;
            win_col    <= reading ? col : '0;
            first_line <= (state == ST_READ) && (line == LINE_TWO);
            last_line  <= (state == ST_LAST);
            rd_ram     <= ((state == ST_READ) && (line != LINE_TWO)) ? rd_rot : RD_ROT_A;
            done_pend  <= (state == ST_LAST) && (col == COL_LAST);
            frame_done <= done_pend;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomised bench for line_buffer_ctrl on a 4x6 image: a cycle-level
// reference built from the frame geometry scores writes, windows and timing.
module tb_line_buffer_ctrl;

    localparam int W  = 4;
    localparam int H  = 6;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [2:0]    wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_ram;
    logic          first_line;
    logic          last_line;
    logic          win_valid;
    logic [AW-1:0] win_col;
    logic          frame_done;

    line_buffer_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_WD(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .rd_ram     (rd_ram),
        .first_line (first_line),
        .last_line  (last_line),
        .win_valid  (win_valid),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // reference model state
    logic [5:0]    exp_wr_q[$];
    logic [6:0]    exp_win_q[$];
    int            pass_q[$];
    bit            in_frame = 0;
    bit            final_ln = 0;
    int            m_line = 0, m_col = 0, hold = 0, nwin = 0, run = 0;
    int            exp_done = -1;
    int            done_seen = 0;
    logic [AW-1:0] prev_rd = '0;

    task automatic build_frame();
        logic [1:0] rot;
        exp_wr_q.delete();
        exp_win_q.delete();
        pass_q.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_wr_q.push_back({3'(1 << (r % 3)), AW'(c)});
        for (int l = 0; l < H; l++) begin
            // centre line l is read after line l+1 lands; the newest line sits in RAM (l+1)%3
            if (l == 0 || l == H - 1) rot = 2'b00;
            else if ((l + 1) % 3 == 0) rot = 2'b10;
            else if ((l + 1) % 3 == 1) rot = 2'b00;
            else rot = 2'b01;
            for (int c = 0; c < W; c++)
                exp_win_q.push_back({(l == 0), (l == H - 1), rot, AW'(c)});
        end
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic       exp_ready, beat;
        logic [5:0] ew;
        logic [6:0] ev;
        bit         was_in_frame;
        cyc++;
        if (rst) begin
            in_frame = 0; final_ln = 0; hold = 0; nwin = 0; run = 0;
            m_line = 0; m_col = 0; exp_done = -1; prev_rd = '0;
            exp_wr_q.delete(); exp_win_q.delete(); pass_q.delete();
        end else begin
            was_in_frame = in_frame;
            exp_ready = in_frame && (hold == 0) && !final_ln;
            check_eq("pix_ready", pix_ready, exp_ready);
            if (hold > 0) hold--;
            beat = pix_valid && exp_ready;
            if (beat || wr_en != 3'b000) check_eq("wr_on_beat", (wr_en != 3'b000), beat);
            if (wr_en != 3'b000) begin
                if (exp_wr_q.size() == 0) check_eq("wr_extra", 1, 0);
                else begin
                    ew = exp_wr_q.pop_front();
                    check_eq("wr_en", wr_en, ew[5:3]);
                    check_eq("wr_addr", wr_addr, ew[2:0]);
                end
            end
            if (beat) begin
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    if (m_line >= 1) begin
                        pass_q.push_back(cyc + 2);
                        hold = W;
                    end
                    if (m_line == H - 1) final_ln = 1;
                    m_line++;
                end
            end
            if (win_valid) begin
                check_eq("first_last_excl", first_line && last_line, 0);
                check_eq("win_align", win_col, prev_rd);
                if (exp_win_q.size() == 0) check_eq("win_extra", 1, 0);
                else begin
                    ev = exp_win_q.pop_front();
                    check_eq("first_line", first_line, ev[6]);
                    check_eq("last_line", last_line, ev[5]);
                    check_eq("rd_ram", rd_ram, ev[4:3]);
                    check_eq("win_col", win_col, ev[2:0]);
                end
                if (win_col == '0 && !last_line) begin
                    if (pass_q.size() == 0) check_eq("pass_extra", 1, 0);
                    else check_eq("pass_start", cyc, pass_q.pop_front());
                end
                nwin++;
                run++;
                if (nwin == H * W) begin
                    exp_done = cyc + 1;
                    in_frame = 0;
                end
            end else begin
                if (run != 0) check_eq("run_len", run % W, 0);
                run = 0;
            end
            if (frame_done || cyc == exp_done) check_eq("frame_done", frame_done, (cyc == exp_done));
            if (frame_done) done_seen++;
            if (start && !was_in_frame) begin
                in_frame = 1; final_ln = 0; hold = 0; nwin = 0;
                m_line = 0; m_col = 0;
                build_frame();
            end
        end
        prev_rd = rd_addr;
    end

    // driver tasks
    task automatic check_all_zero();
        check_eq("rst_pix_ready", pix_ready, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_rd_ram", rd_ram, 0);
        check_eq("rst_first_line", first_line, 0);
        check_eq("rst_last_line", last_line, 0);
        check_eq("rst_win_valid", win_valid, 0);
        check_eq("rst_win_col", win_col, 0);
        check_eq("rst_frame_done", frame_done, 0);
    endtask

    task automatic run_frame(input int pct, input int noise_pct, input bit abort);
        int budget;
        budget = 0;
        @(posedge clk); #1;
        start = 1'b1;
        pix_valid = ($urandom_range(0, 99) < pct);
        @(posedge clk); #1;
        start = 1'b0;
        while (in_frame && budget < 2000) begin
            if (abort && m_line == 3 && m_col == 2) begin
                rst = 1'b1; pix_valid = 1'b0; start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check_all_zero();
                break;
            end
            pix_valid = ($urandom_range(0, 99) < pct);
            start = (nwin < (H - 1) * W) && ($urandom_range(0, 99) < noise_pct);
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        pix_valid = 1'b0;
        if (budget >= 2000) check_eq("frame_timeout", 1, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero();
        run_frame(70, 5, 0);
        run_frame(100, 0, 0);
        run_frame(100, 0, 1);
        repeat (10) @(negedge clk);
        run_frame(100, 25, 0);
        run_frame(55, 10, 0);
        check_eq("wr_q_empty", exp_wr_q.size(), 0);
        check_eq("win_q_empty", exp_win_q.size(), 0);
        check_eq("pass_q_empty", pass_q.size(), 0);
        check_eq("done_count", done_seen, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameter: IMG_W, 640, pixels per line.
REQ-002 Parameter: IMG_H, 480, lines per frame; SHALL satisfy IMG_H mod 3 == 0 and IMG_H >= 3.
REQ-003 Parameter: ADDR_WD, 10, line-RAM address width; SHALL satisfy 2**ADDR_WD >= IMG_W.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: start  in  1  one-cycle frame-start pulse; honoured only in IDLE.
REQ-007 Port: pix_valid  in  1  input pixel present this cycle.
REQ-008 Port: pix_ready  out  1  controller accepts a pixel; a beat transfers when pix_valid && pix_ready.
REQ-009 Port: wr_en  out  3  one-hot write enable for line RAM 0/1/2.
REQ-010 Port: wr_addr  out  ADDR_WD  write column address.
REQ-011 Port: rd_addr  out  ADDR_WD  read column address, shared by all three RAMs.
REQ-012 Port: rd_ram  out  2  rotation select for the 3-line window mux.
REQ-013 Port: first_line  out  1  window is centred on line 0.
REQ-014 Port: last_line  out  1  window is centred on line IMG_H-1.
REQ-015 Port: win_valid  out  1  the window-mux output is valid this cycle.
REQ-016 Port: win_col  out  ADDR_WD  centre column of the current window.
REQ-017 Port: frame_done  out  1  one-cycle pulse after the final window.

Function
REQ-018 States: IDLE, FILL, READ, LAST. Transitions: IDLE->FILL on start. FILL->READ when a line completes and that line index is >= 1. READ->FILL after IMG_W read cycles if lines remain. READ->LAST after the read pass for line IMG_H-1 is written. LAST->IDLE after IMG_W cycles.
REQ-019 FILL: pix_ready=1. Each accepted beat asserts wr_en[r mod 3], where r is the current line, sets wr_addr to the column, and increments the column counter. The column wraps to 0 at IMG_W-1 and r then increments.
REQ-020 pix_ready SHALL be 0 in IDLE, READ and LAST. Stalling input during reads prevents overwriting the RAM that holds the top window row.
REQ-021 READ after line k is written (k>=1): rd_addr steps 0..IMG_W-1, one address per cycle, with no bubbles.
REQ-022 When k=1: first_line=1 and rd_ram=00.
REQ-023 When k>=2, rd_ram is set by k mod 3: 0->10, 1->00, 2->01. The window rows are then k-2, k-1 and k.
REQ-024 LAST: rd_addr steps 0..IMG_W-1 with last_line=1 and rd_ram=00.
REQ-025 Read latency: the line RAMs are synchronous read, 1 cycle. rd_ram, first_line, last_line, win_valid and win_col SHALL be registered one cycle after rd_addr so they align with the RAM data.
REQ-026 Window count: exactly IMG_H*IMG_W win_valid cycles per frame.
REQ-027 frame_done SHALL pulse in the cycle after the last win_valid; the state is IDLE in that same cycle.
REQ-028 A start pulse outside IDLE SHALL be ignored. pix_valid while pix_ready=0 SHALL be held off, with no write.
REQ-029 first_line and last_line SHALL never be asserted together.

Reset
REQ-030 rst SHALL force the state to IDLE and clear all counters.
REQ-031 rst SHALL clear every output to 0: pix_ready, wr_en, wr_addr, rd_addr, rd_ram, first_line, last_line, win_valid, win_col and frame_done.
REQ-032 rst mid-frame SHALL abort the frame with no frame_done. The next start SHALL begin at line 0 in RAM 0.

Structure
REQ-033 Shared package sobel_pkg SHALL hold the state enum and the rd_ram encoding constants (RD_ROT_A=00, RD_ROT_B=01, RD_ROT_C=10).
REQ-034 One sub-module, mod3_rot_cnt, SHALL provide the wrapping 0..2 write-RAM index with increment and clear.

Verification (IMG_W=4, IMG_H=6)
REQ-035 Scenario 1: start, then 4 pixels with continuous pix_valid -> wr_en=001 and wr_addr=0,1,2,3; pix_ready stays 1 into line 1.
REQ-036 Scenario 2: line 1 completes -> pix_ready=0 for 4 cycles. One cycle after rd_addr=0, win_valid=1 with first_line=1, rd_ram=00 and win_col=0..3.
REQ-037 Scenario 3: lines 2, 3 and 4 complete -> rd_ram=01, 10 and 00 respectively. first_line=0 and last_line=0 throughout.
REQ-038 Scenario 4: line 5 completes -> a rd_ram=01 pass, then a LAST pass with last_line=1. frame_done pulses after 24 total win_valid cycles.
REQ-039 Scenario 5: rst asserted mid-line 3 -> all outputs 0 the next cycle. A new start then writes wr_en=001, and no frame_done is seen for the aborted frame.
REQ-040 Scenario 6: start pulsed during READ, and pix_valid held 1 during READ -> no state change and no wr_en asserted.
